// File: rtl/shift_cmd_issue.sv
// Pipelined command front-end for an external 8-bit funnel/barrel shifter.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_n/
//   in_op/in_chain command input; sh_i/sh_n/sh_ar/sh_lr/sh_rot drive the
//   shifter, sh_o returns its result; out_valid/out_ready/out_data result
//   output; busy = any stage occupied.
module shift_cmd_issue #(
    parameter int W  = 8,
    parameter int NW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [NW-1:0] in_n,
    input  logic [1:0]    in_op,
    input  logic          in_chain,
    output logic [W-1:0]  sh_i,
    output logic [NW-1:0] sh_n,
    output logic          sh_ar,
    output logic          sh_lr,
    output logic          sh_rot,
    input  logic [W-1:0]  sh_o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    localparam logic [NW-1:0] MAX_N = NW'(W);

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_LSL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic          s1_valid;
    logic [W-1:0]  s1_data;
    logic [NW-1:0] s1_n;
    logic [1:0]    s1_op;
    logic [W-1:0]  last;

    logic out_adv;
    logic s1_adv;
    logic accept;

    assign out_adv  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && out_adv;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;
    assign busy     = s1_valid || out_valid;
    assign sh_i     = s1_data;

    // Shift amounts past the width saturate; rotates wrap modulo the width.
    always_comb begin
        sh_ar  = 1'b0;
        sh_lr  = 1'b0;
        sh_rot = 1'b0;
        sh_n   = (s1_n > MAX_N) ? MAX_N : s1_n;
        unique case (s1_op)
            OP_LSR: ;
            OP_ASR: sh_ar = 1'b1;
            OP_LSL: sh_lr = 1'b1;
            OP_ROR: begin
                sh_rot = 1'b1;
                sh_n   = {1'b0, s1_n[NW-2:0]};
            end
            default: ;
        endcase
    end

    // Result stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            last      <= '0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_data  <= sh_o;
            last      <= sh_o;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Issue stage. A chained command accepted while the previous one
    // retires takes the retiring result straight off the shifter, since
    // last has not caught up with it yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_n     <= '0;
            s1_op    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_n     <= in_n;
            s1_op    <= in_op;
            if (!in_chain)
                s1_data <= in_data;
            else if (s1_adv)
                s1_data <= sh_o;
            else
                s1_data <= last;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_cmd_issue.sv
// Directed, table-driven bench for shift_cmd_issue with a behavioural
// model of the 8-bit shifter closing the sh_* / sh_o loop.
module tb_shift_cmd_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_n;
    logic [1:0] in_op;
    logic       in_chain;
    logic [7:0] sh_i;
    logic [3:0] sh_n;
    logic       sh_ar;
    logic       sh_lr;
    logic       sh_rot;
    logic [7:0] sh_o;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] got[$];

    shift_cmd_issue #(.W(8), .NW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_n(in_n), .in_op(in_op),
        .in_chain(in_chain),
        .sh_i(sh_i), .sh_n(sh_n), .sh_ar(sh_ar),
        .sh_lr(sh_lr), .sh_rot(sh_rot), .sh_o(sh_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] shifter(
        input logic [7:0] x, input logic [3:0] n,
        input logic ar, input logic lr, input logic rot);
        logic [15:0] d;
        d = {x, x} >> n[2:0];
        if (rot) return d[7:0];
        if (lr) return (n >= 4'd8) ? 8'h00 : 8'(x << n);
        if (ar) return (n >= 4'd8) ? {8{x[7]}} : 8'($signed(x) >>> n);
        return (n >= 4'd8) ? 8'h00 : 8'(x >> n);
    endfunction

    always_comb sh_o = shifter(sh_i, sh_n, sh_ar, sh_lr, sh_rot);

    always @(posedge clk)
        if (!rst && out_valid && out_ready) got.push_back(out_data);

    function automatic logic [2:0] mode_of(input logic [1:0] op);
        case (op)
            2'd0: return 3'b000;
            2'd1: return 3'b100;
            2'd2: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d,
                         input logic [3:0] n, input logic [1:0] op,
                         input logic ch);
        in_valid = v;
        in_data  = d;
        in_n     = n;
        in_op    = op;
        in_chain = ch;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [3:0] n;
        logic [1:0] op;
        logic       chain;
        logic [7:0] exp_o;
        logic [3:0] exp_n;
    } vec_t;

    localparam int NV = 16;
    vec_t tv[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{8'h96, 4'd3,  2'd0, 1'b0, 8'h12, 4'd3};
        tv[1]  = '{8'h96, 4'd3,  2'd1, 1'b0, 8'hF2, 4'd3};
        tv[2]  = '{8'h96, 4'd3,  2'd2, 1'b0, 8'hB0, 4'd3};
        tv[3]  = '{8'h96, 4'd3,  2'd3, 1'b0, 8'hD2, 4'd3};
        tv[4]  = '{8'hFF, 4'd12, 2'd0, 1'b0, 8'h00, 4'd8};
        tv[5]  = '{8'h80, 4'd15, 2'd1, 1'b0, 8'hFF, 4'd8};
        tv[6]  = '{8'h96, 4'd12, 2'd3, 1'b0, 8'h69, 4'd4};
        tv[7]  = '{8'h5A, 4'd0,  2'd0, 1'b0, 8'h5A, 4'd0};
        tv[8]  = '{8'h5A, 4'd0,  2'd1, 1'b0, 8'h5A, 4'd0};
        tv[9]  = '{8'h5A, 4'd0,  2'd2, 1'b0, 8'h5A, 4'd0};
        tv[10] = '{8'h5A, 4'd0,  2'd3, 1'b0, 8'h5A, 4'd0};
        tv[11] = '{8'h01, 4'd1,  2'd2, 1'b0, 8'h02, 4'd1};
        tv[12] = '{8'hEE, 4'd2,  2'd2, 1'b1, 8'h08, 4'd2};
        tv[13] = '{8'hEE, 4'd4,  2'd3, 1'b1, 8'h80, 4'd4};
        tv[14] = '{8'hFF, 4'd8,  2'd2, 1'b0, 8'h00, 4'd8};
        tv[15] = '{8'hA5, 4'd8,  2'd3, 1'b0, 8'hA5, 4'd0};

        // Reset held with a command offered: it must never be accepted.
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h55, 4'd1, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 8'h00, 4'd0, 2'd0, 1'b0);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_data", 32'(out_data), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset no result", 32'(got.size()), 0);

        // Back-to-back stream, one command per cycle.
        for (int i = 0; i < NV; i++) begin
            #1;
            drive(1'b1, tv[i].data, tv[i].n, tv[i].op, tv[i].chain);
            #1;
            chk($sformatf("stream in_ready %0d", i), 32'(in_ready), 1);
            if (i >= 1) begin
                chk($sformatf("sh_n %0d", i - 1),
                    32'(sh_n), 32'(tv[i-1].exp_n));
                chk($sformatf("mode %0d", i - 1),
                    32'({sh_ar, sh_lr, sh_rot}),
                    32'(mode_of(tv[i-1].op)));
            end
            if (i >= 2) begin
                chk($sformatf("out_valid %0d", i - 2), 32'(out_valid), 1);
                chk($sformatf("out_data %0d", i - 2),
                    32'(out_data), 32'(tv[i-2].exp_o));
            end
            @(posedge clk);
        end
        #1;
        drive(1'b0, 8'h00, 4'd0, 2'd0, 1'b0);
        #1;
        chk("tail sh_n", 32'(sh_n), 32'(tv[NV-1].exp_n));
        chk("tail out -2", 32'(out_data), 32'(tv[NV-2].exp_o));
        @(posedge clk);
        #1;
        chk("tail valid", 32'(out_valid), 1);
        chk("tail out -1", 32'(out_data), 32'(tv[NV-1].exp_o));
        @(posedge clk);
        #1;
        chk("drained valid", 32'(out_valid), 0);
        chk("drained busy", 32'(busy), 0);
        chk("stream count", 32'(got.size()), NV);

        // Backpressure: two commands fill both stages, third stalls.
        got.delete();
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 4'd0, 2'd0, 1'b0);
        #1;
        chk("bp ready 1", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        drive(1'b1, 8'h22, 4'd0, 2'd0, 1'b0);
        #1;
        chk("bp ready 2", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        drive(1'b1, 8'h33, 4'd0, 2'd0, 1'b0);
        #1;
        chk("bp ready 3", 32'(in_ready), 0);
        chk("bp valid", 32'(out_valid), 1);
        chk("bp hold a", 32'(out_data), 32'h11);
        repeat (2) @(posedge clk);
        #1;
        chk("bp ready held", 32'(in_ready), 0);
        chk("bp hold b", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        #1;
        chk("bp ready rise", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 4'd0, 2'd0, 1'b0);
        for (int k = 0; k < 10 && busy; k++) @(posedge clk);
        #1;
        chk("bp drain timeout", 32'(busy), 0);
        chk("bp count", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("bp order 0", 32'(got[0]), 32'h11);
            chk("bp order 1", 32'(got[1]), 32'h22);
            chk("bp order 2", 32'(got[2]), 32'h33);
        end

        // Reset while both stages hold commands; last must clear too.
        out_ready = 1'b0;
        drive(1'b1, 8'hAB, 4'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 8'hCD, 4'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 4'd0, 2'd0, 1'b0);
        #1;
        chk("mid s1+out busy", 32'(busy), 1);
        chk("mid out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid rst valid", 32'(out_valid), 0);
        chk("mid rst busy", 32'(busy), 0);
        out_ready = 1'b1;
        drive(1'b1, 8'h77, 4'd1, 2'd2, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 4'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("post rst chain valid", 32'(out_valid), 1);
        chk("post rst chain data", 32'(out_data), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_cmd_issue.md
Name: shift_cmd_issue

Overview:
- Pipelined command front-end for the 8-bit combinational funnel/barrel shifter (ports i, n, ar, lr, rot, o).
- Accepts shift commands over a valid/ready handshake and registers them into an issue stage that drives the shifter.
- Captures the shifter result into an output register with valid/ready backpressure.
- Supports chaining: a command may take the previous result as its operand, which allows multi-step shift sequences without software round-trips.

Parameters:
- W, 8, data width; fixed by the shifter. The block supports only W=8.
- NW, 4, shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready at rising edge.
- in_data  in  8  operand; ignored when in_chain=1.
- in_n  in  4  shift amount, 0..15.
- in_op  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- in_chain  in  1  1 = use previous result as operand.
- sh_i  out  8  operand to shifter.
- sh_n  out  4  amount to shifter.
- sh_ar, sh_lr, sh_rot  out  1 each  mode to shifter.
- sh_o  in  8  shifter result (combinational from sh_* outputs).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  8  result.
- busy  out  1  s1_valid | out_valid.

Behaviour:
- State:
  - s1_valid, s1_data[7:0], s1_n[3:0], s1_op[1:0] (issue stage).
  - out_valid, out_data (result stage).
  - last[7:0] (most recent result loaded into the result stage).
- Reset: s1_valid=0, out_valid=0, out_data=0, last=0, s1_data=0, s1_n=0, s1_op=0. Reset overrides any simultaneous handshake; in-flight commands are discarded.
- Shifter drive, combinational from the issue stage:
  - sh_i = s1_data.
  - op 00: ar=0, lr=0, rot=0.
  - op 01: ar=1, lr=0, rot=0.
  - op 10: lr=1, ar=0, rot=0.
  - op 11: rot=1, ar=0, lr=0.
  - sh_n: for ops 00/01/10, min(s1_n, 8) (amounts 9..15 clamp to 8). For op 11, {1'b0, s1_n[2:0]} (rotate mod 8).
- Advance rules:
  - out_adv = !out_valid | out_ready.
  - s1_adv = s1_valid & out_adv.
  - in_ready = !s1_valid | s1_adv. This is combinational; in_ready never depends on in_valid.
- Result stage:
  - On s1_adv: out_data <= sh_o, last <= sh_o, out_valid <= 1.
  - Else if out_valid & out_ready: out_valid <= 0.
  - out_data and last hold otherwise.
- Issue stage:
  - On accept: s1_valid <= 1; capture n/op.
  - Else if s1_adv: s1_valid <= 0.
- Chain operand on accept with in_chain=1:
  - If s1_adv this cycle: s1_data <= sh_o (forward the result being retired).
  - Otherwise: s1_data <= last.
  - Chaining after reset with no prior result uses last=0.
- Latency and throughput:
  - Command accepted at edge k; out_valid=1 after edge k+1.
  - Sustained throughput of 1 command/cycle while out_ready=1.
- Backpressure:
  - With out_ready held low, at most 2 commands are held (issue stage + result stage); in_ready=0 thereafter.
  - No command is dropped or duplicated; results are delivered in acceptance order.
  - out_data is stable while out_valid & !out_ready.
- Amount 0 on any op yields the operand unchanged. Logical left by 8 yields 0x00.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, busy=0, in_ready=1 after release; no result ever emitted for the command presented during reset.
- Modes on 0x96 with n=3, back-to-back, out_ready=1:
  - op00 -> 0x12, op01 -> 0xF2, op10 -> 0xB0, op11 -> 0xD2.
  - Results appear on consecutive cycles, first one 2 edges after first accept.
- Clamp and wrap:
  - 0xFF op00 n=12 -> 0x00.
  - 0x80 op01 n=15 -> 0xFF.
  - 0x96 op11 n=12 -> 0x69.
  - 0x5A any op n=0 -> 0x5A.
  - Monitor sh_n: 8 for the first two cases, 4 for the rotate.
- Chain with forwarding: 0x01 op10 n=1, then next cycle in_chain=1 op10 n=2, then in_chain=1 op11 n=4 -> outputs 0x02, 0x08, 0x80 on consecutive cycles.
- Backpressure: out_ready=0, offer 3 commands (0x11, 0x22, 0x33 op00 n=0).
  - in_ready drops after 2 accepts.
  - out_data holds 0x11 stable.
  - Raise out_ready -> 0x11, 0x22, 0x33 in order, no duplicates.
- Reset mid-operation: assert rst with s1_valid=1 and out_valid=1 -> both cleared next edge; a subsequent chained command uses operand 0x00 (0x00 op10 n=1 -> 0x00).
